// File: rtl/emu_clk_pkg.sv
// Shared types and constants for the emulator clock-enable generator.
// Optional tick counters are enabled by defining EMU_CLK_TICK_CNT_EN.
package emu_clk_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int TICK_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/emu_clk_div_chan.sv
// One divider channel: run/drain FSM, period counter, active and shadow
// period registers, registered enable/square-wave outputs.
// EMU_CLK_TICK_CNT_EN adds a free-running count of clk_en pulses.
module emu_clk_div_chan
  import emu_clk_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 1
) (
  input  logic             emu_clk,
  input  logic             emu_rst,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_ld,
  input  logic             run_req,
  input  logic             sync_all,
  output logic             running,
  output logic             clk_en,
  output logic             clk_div
`ifdef EMU_CLK_TICK_CNT_EN
  ,
  output logic [TICK_W-1:0] tick_cnt
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic [DIV_W-1:0] div_shadow_q, div_shadow_d;
  logic             running_q, running_d;
  logic             clk_en_q, clk_en_d;
  logic             clk_div_q, clk_div_d;
  logic [DIV_W-1:0] shadow_nxt;
  logic             wrap;

  // State register: FSM, counters and registered outputs
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_reg_q    <= DIV_W'(DIV_RST);
      div_shadow_q <= DIV_W'(DIV_RST);
      running_q    <= 1'b0;
      clk_en_q     <= 1'b0;
      clk_div_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_reg_q    <= div_reg_d;
      div_shadow_q <= div_shadow_d;
      running_q    <= running_d;
      clk_en_q     <= clk_en_d;
      clk_div_q    <= clk_div_d;
    end
  end

  // Next state: counting, period reload at wrap or sync, drain exit at wrap
  always_comb begin
    // A load in the same cycle as a wrap or sync is taken by that reload,
    // so the new period starts immediately after the boundary.
    shadow_nxt   = div_ld ? div_val : div_shadow_q;
    wrap         = (cnt_q == div_reg_q);
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_reg_d    = div_reg_q;
    div_shadow_d = shadow_nxt;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (div_ld) div_reg_d = div_val;
        if (run_req) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (sync_all || wrap) begin
          cnt_d     = '0;
          div_reg_d = shadow_nxt;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        // sync_all outranks the drain exit: the drain then runs a fresh period
        if (run_req)                 state_d = RUN;
        else if (state_q == RUN)     state_d = DRAIN;
        else if (wrap && !sync_all)  state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: decoded from next-state values so they register cleanly
  always_comb begin
    running_d = (state_d != IDLE);
    clk_en_d  = running_d && (cnt_d == '0);
    clk_div_d = running_d && (cnt_d <= (div_reg_d >> 1));
  end

  assign running = running_q;
  assign clk_en  = clk_en_q;
  assign clk_div = clk_div_q;

`ifdef EMU_CLK_TICK_CNT_EN
  logic [TICK_W-1:0] tick_q, tick_d;

  // Tick counter: counts enable pulses, survives return to IDLE
  always_comb begin
    tick_d = tick_q + TICK_W'(clk_en_q);
  end

  // Tick counter register, cleared only by reset
  always_ff @(posedge emu_clk) begin
    if (emu_rst) tick_q <= '0;
    else         tick_q <= tick_d;
  end

  assign tick_cnt = tick_q;
`endif

endmodule

// File: rtl/emu_clk_div_gen.sv
// Multi-channel clock-enable generator for the emulator clock domain.
// Instantiates N_CH divider channels sharing div_val and sync_all.
// Defining EMU_CLK_TICK_CNT_EN adds the packed tick_cnt output.
module emu_clk_div_gen
  import emu_clk_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 1
) (
  input  logic             emu_clk,
  input  logic             emu_rst,
  input  logic [DIV_W-1:0] div_val,
  input  logic [N_CH-1:0]  div_ld,
  input  logic [N_CH-1:0]  run_req,
  input  logic             sync_all,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  clk_en,
  output logic [N_CH-1:0]  clk_div
`ifdef EMU_CLK_TICK_CNT_EN
  ,
  output logic [N_CH*TICK_W-1:0] tick_cnt
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
`ifdef EMU_CLK_TICK_CNT_EN
    emu_clk_div_chan #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_chan (
      .emu_clk  (emu_clk),
      .emu_rst  (emu_rst),
      .div_val  (div_val),
      .div_ld   (div_ld[i]),
      .run_req  (run_req[i]),
      .sync_all (sync_all),
      .running  (running[i]),
      .clk_en   (clk_en[i]),
      .clk_div  (clk_div[i]),
      .tick_cnt (tick_cnt[i*TICK_W +: TICK_W])
    );
`else
    emu_clk_div_chan #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_chan (
      .emu_clk  (emu_clk),
      .emu_rst  (emu_rst),
      .div_val  (div_val),
      .div_ld   (div_ld[i]),
      .run_req  (run_req[i]),
      .sync_all (sync_all),
      .running  (running[i]),
      .clk_en   (clk_en[i]),
      .clk_div  (clk_div[i])
    );
`endif
  end

endmodule

// File: tb/tb_emu_clk_div_gen.sv
// Directed scoreboard bench for emu_clk_div_gen (4 channels, 16-bit periods).
module tb_emu_clk_div_gen;

  localparam int N_CH  = 4;
  localparam int DIV_W = 16;

  logic             emu_clk = 1'b0;
  logic             emu_rst;
  logic [DIV_W-1:0] div_val;
  logic [N_CH-1:0]  div_ld;
  logic [N_CH-1:0]  run_req;
  logic             sync_all;
  logic [N_CH-1:0]  running;
  logic [N_CH-1:0]  clk_en;
  logic [N_CH-1:0]  clk_div;
`ifdef EMU_CLK_TICK_CNT_EN
  logic [N_CH*32-1:0] tick_cnt;
`endif

  emu_clk_div_gen #(.N_CH(N_CH), .DIV_W(DIV_W), .DIV_RST(1)) dut (
    .emu_clk  (emu_clk),
    .emu_rst  (emu_rst),
    .div_val  (div_val),
    .div_ld   (div_ld),
    .run_req  (run_req),
    .sync_all (sync_all),
    .running  (running),
    .clk_en   (clk_en),
    .clk_div  (clk_div)
`ifdef EMU_CLK_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  always #5 emu_clk = ~emu_clk;

  typedef struct {
    string           tag;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] dv;
    logic [N_CH-1:0] rn;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [N_CH-1:0] en,
                      input logic [N_CH-1:0] dv, input logic [N_CH-1:0] rn);
    exp_t e;
    e.tag = tag; e.en = en; e.dv = dv; e.rn = rn;
    sbq.push_back(e);
  endtask

  // Advance n cycles, popping one expectation per cycle, sampled 1 time unit after the edge
  task automatic run_cyc(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge emu_clk);
      #1;
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, ".clk_en"},  32'(clk_en),  32'(e.en));
        chk({e.tag, ".clk_div"}, 32'(clk_div), 32'(e.dv));
        chk({e.tag, ".running"}, 32'(running), 32'(e.rn));
      end
    end
  endtask

  task automatic do_reset(input string tag);
    emu_rst = 1'b1; div_ld = '0; run_req = '0; sync_all = 1'b0;
    push(tag, 4'b0, 4'b0, 4'b0);
    run_cyc(1);
    emu_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    emu_rst = 1'b1; div_val = '0; div_ld = '0; run_req = '0; sync_all = 1'b0;
    do_reset("reset");

    // Basic run, P=4: enable every 4 cycles, square wave 1,1,0,0
    div_val = 16'd3; div_ld = 4'b0001;
    push("ld_idle", 4'b0, 4'b0, 4'b0);
    run_cyc(1);
    div_ld = '0; run_req = 4'b0001;
    for (int k = 0; k < 10; k++)
      push("basic", ((k % 4) == 0) ? 4'b0001 : 4'b0000,
                    ((k % 4) < 2)  ? 4'b0001 : 4'b0000, 4'b0001);
    run_cyc(10);

    // Clean stop: drop at cnt=1, drain through cnt=3, no further enable
    run_req = '0;
    push("drain_c2", 4'b0, 4'b0, 4'b0001);
    push("drain_c3", 4'b0, 4'b0, 4'b0001);
    push("stopped",  4'b0, 4'b0, 4'b0);
    push("stopped",  4'b0, 4'b0, 4'b0);
    run_cyc(4);

    // Period change mid-run: load P=2 at cnt=2, current P=4 period completes
    run_req = 4'b0001;
    push("chg_c0", 4'b0001, 4'b0001, 4'b0001);
    push("chg_c1", 4'b0000, 4'b0001, 4'b0001);
    push("chg_c2", 4'b0000, 4'b0000, 4'b0001);
    run_cyc(3);
    div_val = 16'd1; div_ld = 4'b0001;
    push("chg_c3", 4'b0000, 4'b0000, 4'b0001);
    run_cyc(1);
    div_ld = '0;
    for (int k = 0; k < 4; k++)
      push("chg_p2", (k % 2 == 0) ? 4'b0001 : 4'b0000,
                     (k % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0001);
    run_cyc(4);
    do_reset("rst_mid");

    // Phase align: ch0 P=3, ch1 P=5 out of phase, then sync_all
    div_val = 16'd2; div_ld = 4'b0001;
    push("ld_ch0", 4'b0, 4'b0, 4'b0);
    run_cyc(1);
    div_val = 16'd4; div_ld = 4'b0010;
    push("ld_ch1", 4'b0, 4'b0, 4'b0);
    run_cyc(1);
    div_ld = '0; run_req = 4'b0001;
    push("ph_a", 4'b0001, 4'b0001, 4'b0001);
    run_cyc(1);
    run_req = 4'b0011;
    push("ph_b", 4'b0010, 4'b0011, 4'b0011);
    run_cyc(1);
    sync_all = 1'b1;
    push("sync", 4'b0011, 4'b0011, 4'b0011);
    run_cyc(1);
    sync_all = 1'b0;
    push("post_sync1", 4'b0000, 4'b0011, 4'b0011);
    push("post_sync2", 4'b0000, 4'b0010, 4'b0011);
    push("post_sync3", 4'b0001, 4'b0001, 4'b0011);
    run_cyc(3);
    do_reset("rst_sync");

    // P=1: enable and square wave stay high
    div_val = 16'd0; div_ld = 4'b0001; run_req = 4'b0001;
    push("p1", 4'b0001, 4'b0001, 4'b0001);
    run_cyc(1);
    div_ld = '0;
    for (int k = 0; k < 3; k++) push("p1", 4'b0001, 4'b0001, 4'b0001);
    run_cyc(3);

    // Reset mid-run with a concurrent load: load discarded, P back to 2
    emu_rst = 1'b1; div_val = 16'd5; div_ld = 4'b0001;
    push("rst_p1", 4'b0, 4'b0, 4'b0);
    run_cyc(1);
    emu_rst = 1'b0; div_ld = '0;
    for (int k = 0; k < 5; k++)
      push("p2_after_rst", (k % 2 == 0) ? 4'b0001 : 4'b0000,
                           (k % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0001);
    run_cyc(5);
    run_req = '0;
    push("p2_drain", 4'b0, 4'b0, 4'b0001);
    push("p2_idle",  4'b0, 4'b0, 4'b0);
    run_cyc(2);

`ifdef EMU_CLK_TICK_CNT_EN
    // Tick counter: 10 periods of P=2, then stop; count holds in IDLE
    do_reset("rst_tick");
    run_req = 4'b0001;
    for (int k = 0; k < 19; k++)
      push("tick_run", (k % 2 == 0) ? 4'b0001 : 4'b0000,
                       (k % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0001);
    run_cyc(19);
    run_req = '0;
    push("tick_drain", 4'b0, 4'b0, 4'b0001);
    push("tick_idle",  4'b0, 4'b0, 4'b0);
    push("tick_idle",  4'b0, 4'b0, 4'b0);
    run_cyc(3);
    chk("tick_cnt0", tick_cnt[31:0], 32'd10);
    chk("tick_cnt1", tick_cnt[63:32], 32'd0);
    push("tick_hold", 4'b0, 4'b0, 4'b0);
    push("tick_hold", 4'b0, 4'b0, 4'b0);
    run_cyc(2);
    chk("tick_cnt0_hold", tick_cnt[31:0], 32'd10);
`endif

    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
